// File: rtl/cordic_pkg.sv
// Shared constants, mode encodings and FSM states for the cordic angle-prep slice.
// Optional feature macro: CORDIC_PREP_DEG_EN (angle input in degrees).
package cordic_pkg;

    localparam int TWO_PI  = 411775;
    localparam int PI      = 205887;
    localparam int HALF_PI = 102944;

    localparam int DEG_360 = 23592960;
    localparam int DEG_180 = 11796480;
    localparam int DEG_90  = 5898240;
    localparam int DEG2RAD = 1144;

`ifdef CORDIC_PREP_DEG_EN
    localparam int RED_FULL    = DEG_360;
    localparam int RED_HALF    = DEG_180;
    localparam int RED_QUARTER = DEG_90;
`else
    localparam int RED_FULL    = TWO_PI;
    localparam int RED_HALF    = PI;
    localparam int RED_QUARTER = HALF_PI;
`endif

    localparam logic       MODE_ROTATION  = 1'b0;
    localparam logic [1:0] COORD_CIRCULAR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_FOLD,
        ST_CONV,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } prep_state_e;

endpackage

// File: rtl/cordic_angle_reduce.sv
// Restoring argument reduction of |angle| into one turn, then fold into [-quarter, +quarter].
// Turn constants switch to degrees when CORDIC_PREP_DEG_EN is defined.
module cordic_angle_reduce
    import cordic_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RED_STEPS = 13,
    parameter int KW        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] angle,
    input  logic                    step,
    input  logic [KW-1:0]           step_k,
    output logic signed [WIDTH-1:0] z,
    output logic                    flip
);

    // Compare width leaves room for the full turn shifted by the largest step in either unit.
    localparam int CW = WIDTH + RED_STEPS;

    localparam logic signed [WIDTH-1:0] C_FULL    = WIDTH'(RED_FULL);
    localparam logic signed [WIDTH-1:0] C_HALF    = WIDTH'(RED_HALF);
    localparam logic signed [WIDTH-1:0] C_QUARTER = WIDTH'(RED_QUARTER);
    localparam logic signed [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] C_MAX     = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0]        mag;
    logic                    sign;
    logic [WIDTH-1:0]        abs_angle;
    logic [CW-1:0]           step_sub;
    logic                    step_take;
    logic signed [WIDTH-1:0] r_wrap;

    always_comb begin
        abs_angle = angle;
        if (angle == C_MIN) begin
            abs_angle = C_MAX;
        end else if (angle[WIDTH-1]) begin
            abs_angle = -angle;
        end
        step_sub  = CW'(C_FULL) << step_k;
        step_take = CW'(mag) >= step_sub;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag  <= '0;
            sign <= 1'b0;
        end else if (load) begin
            mag  <= abs_angle;
            sign <= angle[WIDTH-1];
        end else if (step && step_take) begin
            mag <= mag - step_sub[WIDTH-1:0];
        end
    end

    // Restore the sign in [0, turn), recentre to [-half, half), then mirror into the quarter range.
    always_comb begin
        r_wrap = $signed(mag);
        z      = '0;
        flip   = 1'b0;
        if (sign) begin
            r_wrap = (mag == '0) ? '0 : C_FULL - $signed(mag);
        end
        if (r_wrap >= C_HALF) begin
            r_wrap = r_wrap - C_FULL;
        end
        if (r_wrap > C_QUARTER) begin
            z    = C_HALF - r_wrap;
            flip = 1'b1;
        end else if (r_wrap < -C_QUARTER) begin
            z    = -C_HALF - r_wrap;
            flip = 1'b1;
        end else begin
            z = r_wrap;
        end
    end

endmodule

// File: rtl/cordic_angle_prep.sv
// Sequencer around the cordic core: reduce angle, issue rotation, fix up quadrant sign.
// Define CORDIC_PREP_DEG_EN to accept degrees (adds a CONV state before ISSUE).
module cordic_angle_prep
    import cordic_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int RED_STEPS = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] angle_in,
    output logic                    cordic_en,
    output logic                    cordic_mode_op,
    output logic [1:0]              cordic_mode_coord,
    output logic signed [WIDTH-1:0] cordic_x,
    output logic signed [WIDTH-1:0] cordic_y,
    output logic signed [WIDTH-1:0] cordic_z,
    input  logic signed [WIDTH-1:0] cordic_xo,
    input  logic signed [WIDTH-1:0] cordic_yo,
    input  logic                    cordic_valid,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int KW = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

    prep_state_e             state;
    prep_state_e             state_next;
    logic [KW-1:0]           step_k;
    logic                    flip_q;
    logic signed [WIDTH-1:0] fold_z;
    logic                    fold_flip;
    logic                    accept;

    assign accept            = (state == ST_IDLE) && in_valid;
    assign cordic_mode_op    = MODE_ROTATION;
    assign cordic_mode_coord = COORD_CIRCULAR;
    assign cordic_x          = ONE;
    assign cordic_y          = '0;

    cordic_angle_reduce #(
        .WIDTH     (WIDTH),
        .RED_STEPS (RED_STEPS),
        .KW        (KW)
    ) u_reduce (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .angle  (angle_in),
        .step   (state == ST_REDUCE),
        .step_k (step_k),
        .z      (fold_z),
        .flip   (fold_flip)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cordic_en  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_REDUCE;
            end
            ST_REDUCE: begin
                if (step_k == '0) state_next = ST_FOLD;
            end
`ifdef CORDIC_PREP_DEG_EN
            ST_FOLD:  state_next = ST_CONV;
            ST_CONV:  state_next = ST_ISSUE;
`else
            ST_FOLD:  state_next = ST_ISSUE;
`endif
            ST_ISSUE: begin
                cordic_en  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cordic_valid) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef CORDIC_PREP_DEG_EN
    logic signed [2*WIDTH-1:0] conv_prod;
    logic signed [2*WIDTH-1:0] conv_shift;
    assign conv_prod  = (2*WIDTH)'(cordic_z) * (2*WIDTH)'(DEG2RAD);
    assign conv_shift = conv_prod >>> FRAC;
`endif

    // cordic_z is only written in FOLD/CONV, so it stays put through ISSUE and WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_k   <= '0;
            cordic_z <= '0;
            flip_q   <= 1'b0;
            cos_out  <= '0;
            sin_out  <= '0;
        end else begin
            if (accept) begin
                step_k <= KW'(RED_STEPS - 1);
            end else if (state == ST_REDUCE && step_k != '0) begin
                step_k <= step_k - 1'b1;
            end
            if (state == ST_FOLD) begin
                cordic_z <= fold_z;
                flip_q   <= fold_flip;
            end
`ifdef CORDIC_PREP_DEG_EN
            if (state == ST_CONV) begin
                cordic_z <= conv_shift[WIDTH-1:0];
            end
`endif
            if (state == ST_WAIT && cordic_valid) begin
                cos_out <= flip_q ? -cordic_xo : cordic_xo;
                sin_out <= cordic_yo;
            end
        end
    end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Randomized self-checking bench for cordic_angle_prep with a behavioural cordic core model.
// Honours CORDIC_PREP_DEG_EN when the design is built in degree mode.
module tb_cordic_angle_prep;

`ifdef CORDIC_PREP_DEG_EN
    localparam longint B_TWO   = 23592960;
    localparam longint B_PI    = 11796480;
    localparam longint B_HALF  = 5898240;
    localparam int     LAT_ADD = 1;
    localparam real    UNIT    = 3.14159265358979 / 180.0;
`else
    localparam longint B_TWO   = 411775;
    localparam longint B_PI    = 205887;
    localparam longint B_HALF  = 102944;
    localparam int     LAT_ADD = 0;
    localparam real    UNIT    = 1.0;
`endif
    localparam int RED_STEPS = 13;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] angle_in;
    logic               cordic_en;
    logic               cordic_mode_op;
    logic [1:0]         cordic_mode_coord;
    logic signed [31:0] cordic_x;
    logic signed [31:0] cordic_y;
    logic signed [31:0] cordic_z;
    logic signed [31:0] cordic_xo;
    logic signed [31:0] cordic_yo;
    logic               cordic_valid;
    logic signed [31:0] cos_out;
    logic signed [31:0] sin_out;
    logic               out_valid;
    logic               out_ready;

    int checks   = 0;
    int failures = 0;

    // Core model state
    int                 core_lat     = 3;
    bit                 core_level   = 1'b0;
    bit                 core_garbage = 1'b0;
    int                 core_cnt;
    logic               core_valid;
    logic signed [31:0] core_xo;
    logic signed [31:0] core_yo;

    int                 en_pulses  = 0;
    int                 outv_seen  = 0;
    logic signed [31:0] z_at_en    = '0;

    always #5 clk = ~clk;

    cordic_angle_prep #(
        .WIDTH     (32),
        .FRAC      (16),
        .RED_STEPS (RED_STEPS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .angle_in          (angle_in),
        .cordic_en         (cordic_en),
        .cordic_mode_op    (cordic_mode_op),
        .cordic_mode_coord (cordic_mode_coord),
        .cordic_x          (cordic_x),
        .cordic_y          (cordic_y),
        .cordic_z          (cordic_z),
        .cordic_xo         (cordic_xo),
        .cordic_yo         (cordic_yo),
        .cordic_valid      (cordic_valid),
        .cos_out           (cos_out),
        .sin_out           (sin_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    function automatic int coreCos(input longint z);
        return $rtoi($floor(65536.0 * $cos(real'(z) / 65536.0) + 0.5));
    endfunction

    function automatic int coreSin(input longint z);
        return $rtoi($floor(65536.0 * $sin(real'(z) / 65536.0) + 0.5));
    endfunction

    // The cordic returns unit-gain cos/sin of the z it sees when it fires; a garbage
    // valid can be injected exactly in the enable cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_cnt   <= 0;
            core_valid <= 1'b0;
            core_xo    <= '0;
            core_yo    <= '0;
        end else if (cordic_en) begin
            core_cnt   <= core_lat;
            core_valid <= 1'b0;
        end else begin
            if (core_cnt == 1) begin
                core_valid <= 1'b1;
                core_xo    <= coreCos(longint'(cordic_z));
                core_yo    <= coreSin(longint'(cordic_z));
            end else if (!core_level) begin
                core_valid <= 1'b0;
            end
            if (core_cnt > 0) core_cnt <= core_cnt - 1;
        end
    end

    assign cordic_valid = core_valid | (core_garbage & cordic_en);
    assign cordic_xo    = (core_garbage && cordic_en) ? 32'sd12345 : core_xo;
    assign cordic_yo    = (core_garbage && cordic_en) ? -32'sd777  : core_yo;

    always @(negedge clk) begin
        if (rst && cordic_en) begin
            en_pulses = en_pulses + 1;
            z_at_en   = cordic_z;
        end
        if (rst && out_valid) outv_seen = outv_seen + 1;
    end

    // Angle reduction by plain modulo and quadrant mirroring.
    function automatic void refModel(input int angle, output longint z, output bit flip);
        longint mag;
        longint r;
        mag = longint'(angle);
        if (mag < 0) mag = -mag;
        if (mag > 64'sd2147483647) mag = 64'sd2147483647;
        mag = mag % B_TWO;
        r = (angle < 0) ? ((mag == 0) ? 0 : B_TWO - mag) : mag;
        if (r >= B_PI) r = r - B_TWO;
        flip = 1'b1;
        if (r > B_HALF)       z = B_PI - r;
        else if (r < -B_HALF) z = -B_PI - r;
        else begin
            z    = r;
            flip = 1'b0;
        end
`ifdef CORDIC_PREP_DEG_EN
        z = (z * 1144) >>> 16;
`endif
    endfunction

    task automatic checkOutput(input string tag, input longint actual, input longint expected,
                               input longint tol);
        longint diff;
        checks = checks + 1;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, actual, expected, tol);
        end
    endtask

    task automatic applyStimulus(input int angle, input int lat, input bit level, input bit garbage,
                                 input int hold, input bit second_req, input bit true_check);
        longint exp_z;
        bit     exp_flip;
        longint exp_cos;
        longint exp_sin;
        int     cyc;
        real    ang;
        refModel(angle, exp_z, exp_flip);
        exp_cos = exp_flip ? -coreCos(exp_z) : coreCos(exp_z);
        exp_sin = coreSin(exp_z);
        core_lat     = lat;
        core_level   = level;
        core_garbage = garbage;

        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("in_ready_idle", in_ready, 1, 0);
        in_valid  = 1'b1;
        angle_in  = angle;
        en_pulses = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        angle_in = $urandom;

        cyc = 0;
        while (!out_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("latency", cyc, RED_STEPS + 3 + lat + LAT_ADD, 0);
        checkOutput("en_pulses", en_pulses, 1, 0);
        checkOutput("cordic_z", z_at_en, exp_z, 0);
        checkOutput("cos", cos_out, exp_cos, 0);
        checkOutput("sin", sin_out, exp_sin, 0);
        checkOutput("in_ready_busy", in_ready, 0, 0);
        if (true_check) begin
            ang = real'(angle) / 65536.0 * UNIT;
            checkOutput("cos_true", cos_out, $rtoi($floor(65536.0 * $cos(ang) + 0.5)), 64);
            checkOutput("sin_true", sin_out, $rtoi($floor(65536.0 * $sin(ang) + 0.5)), 64);
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (second_req) begin
                in_valid = 1'b1;
                angle_in = 32'sd154416;
            end
            @(posedge clk);
            #1;
            checkOutput("hold_valid", out_valid, 1, 0);
            checkOutput("hold_cos", cos_out, exp_cos, 0);
            checkOutput("hold_sin", sin_out, exp_sin, 0);
            checkOutput("hold_in_ready", in_ready, 0, 0);
        end

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("accept_drop", out_valid, 0, 0);
        checkOutput("back_idle", in_ready, 1, 0);
        checkOutput("en_total", en_pulses, 1, 0);
    endtask

    int dir_angles[10];
    bit dir_true[10];

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        angle_in  = '0;
        out_ready = 1'b0;
        dir_angles = '{51472, 154416, -1235325, -1286797, 102944, 0, -102944, 411775,
                       int'(32'h80000000), 32'sh7fffffff};
        dir_true   = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1, 0);
        checkOutput("rst_out_valid", out_valid, 0, 0);
        checkOutput("rst_en", cordic_en, 0, 0);
        checkOutput("rst_x", cordic_x, 65536, 0);
        checkOutput("rst_coord", cordic_mode_coord, 1, 0);
        checkOutput("rst_op", cordic_mode_op, 0, 0);
        checkOutput("rst_z", cordic_z, 0, 0);
        checkOutput("rst_cos", cos_out, 0, 0);
        checkOutput("rst_sin", sin_out, 0, 0);
        #2 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(dir_angles[i], 1 + (i % 4), 1'b0, 1'b0, 0, 1'b0, dir_true[i]);
        end

        applyStimulus(51472, 4, 1'b0, 1'b0, 5, 1'b1, 1'b1);
        applyStimulus(154416, 2, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        applyStimulus(-51472, 3, 1'b1, 1'b0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int a;
            a = (i % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 4000000)) - 2000000;
            applyStimulus(a, int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        core_level   = 1'b0;
        core_garbage = 1'b0;
        core_lat     = 3;
        @(negedge clk);
        in_valid = 1'b1;
        angle_in = 32'sd51472;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1, 0);
        checkOutput("midrst_out_valid", out_valid, 0, 0);
        #1 rst = 1'b1;
        en_pulses = 0;
        outv_seen = 0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midrst_no_en", en_pulses, 0, 0);
        checkOutput("midrst_no_out", outv_seen, 0, 0);
        applyStimulus(51472, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
